// File: rtl/dm_resp_pkg.sv
// rtl/dm_resp_pkg.sv - shared types and constants for the dm_4k_resp data-memory responder
//
// Purpose: state encoding, default wait-state count, byte-enable constants and
//          the alignment classifier used when DM_ALIGN_CHK_EN is defined.
// Ports:   none (package).
`timescale 1ns/1ps
package dm_resp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dm_state_e;

  localparam int DEFAULT_LATENCY = 2;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;

  // Reads are always word reads, so any non-zero lane offset is misaligned.
  // Writes are judged by the width implied by the byte-enable pattern; other
  // patterns (single bytes, sparse lanes) are never flagged.
  function automatic logic is_misaligned(input logic we, input logic [3:0] be,
                                         input logic [1:0] lo);
    logic r;
    r = 1'b0;
    if (!we) begin
      r = (lo != 2'b00);
    end else if (be == BE_WORD) begin
      r = (lo != 2'b00);
    end else if ((be == BE_HALF_LO) || (be == BE_HALF_HI)) begin
      r = lo[0];
    end
    return r;
  endfunction

endpackage

// File: rtl/dm_wait_cnt.sv
// rtl/dm_wait_cnt.sv - 4-bit loadable down-counter timing the responder wait states
//
// Purpose: holds the remaining wait-state count; saturates at zero.
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset (count -> 0)
//   i_load     in   load i_load_val (has priority over i_en)
//   i_load_val in   value to load
//   i_en       in   decrement by one when non-zero
//   o_zero     out  count is zero
`timescale 1ns/1ps
module dm_wait_cnt (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  input  logic       i_en,
  output logic       o_zero
);

  logic [3:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= 4'd0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  assign o_zero = (r_cnt == 4'd0);

endmodule

// File: rtl/dm_4k_resp.sv
// rtl/dm_4k_resp.sv - 4 KB word-array data memory behind a req/ack handshake with wait states
//
// Purpose: target end of the CPU load/store interface. An access is accepted in
//          IDLE, waits LATENCY cycles, and completes in a single RESP cycle.
//          Optional macro: DM_ALIGN_CHK_EN adds the err output and suppresses
//          misaligned writes.
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-low reset
//   req    in   access request, held until ack
//   we     in   1 = write, 0 = read
//   addr   in   byte address [ADDR_W+1:0]; [1:0] is the lane offset
//   be     in   write byte enables (be[0] -> bits 7:0)
//   wdata  in   lane-aligned write data
//   rdata  out  read data, valid in the ack cycle; held across writes
//   ack    out  one-cycle completion pulse
//   busy   out  high from accept through the ack cycle
//   err    out  (DM_ALIGN_CHK_EN only) misaligned access, with ack
`timescale 1ns/1ps
module dm_4k_resp
  import dm_resp_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W+1:0] addr,
  input  logic [3:0]        be,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ack,
  output logic              busy
`ifdef DM_ALIGN_CHK_EN
  ,
  output logic              err
`endif
);

  localparam logic [3:0] LOAD_VAL = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  dm_state_e         r_state;
  dm_state_e         w_next;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [3:0]        r_be;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic [31:0]       r_mem [2**ADDR_W];

  logic              w_load;
  logic              w_en;
  logic              w_zero;
  logic              w_ack;
  logic              w_busy;
  logic              w_accept;
  logic              w_acc_we;
  logic [ADDR_W-1:0] w_acc_addr;
  logic              w_enter_resp;
  logic              w_commit;

  dm_wait_cnt u_wait_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (LOAD_VAL),
    .i_en       (w_en),
    .o_zero     (w_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_en   = 1'b0;
    w_ack  = 1'b0;
    w_busy = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req) begin
          if (LATENCY == 0) begin
            w_next = ST_RESP;
          end else begin
            w_next = ST_WAIT;
            w_load = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        w_busy = 1'b1;
        if (w_zero) begin
          w_next = ST_RESP;
        end else begin
          w_en = 1'b1;
        end
      end
      ST_RESP: begin
        w_ack  = 1'b1;
        w_busy = 1'b1;
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  assign ack   = w_ack;
  assign busy  = w_busy;
  assign rdata = r_rdata;

  assign w_accept = (r_state == ST_IDLE) && req;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_be    <= 4'd0;
      r_wdata <= 32'd0;
    end else if (w_accept) begin
      r_addr  <= addr[ADDR_W+1:2];
      r_we    <= we;
      r_be    <= be;
      r_wdata <= wdata;
    end
  end

`ifdef DM_ALIGN_CHK_EN
  logic [1:0] r_lo;
  logic       w_misaligned;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lo <= 2'd0;
    end else if (w_accept) begin
      r_lo <= addr[1:0];
    end
  end

  assign w_misaligned = is_misaligned(r_we, r_be, r_lo);
  assign err          = (r_state == ST_RESP) && w_misaligned;
  assign w_commit     = (r_state == ST_RESP) && r_we && !w_misaligned;
`else
  logic w_unused_lane;
  assign w_unused_lane = ^addr[1:0];
  assign w_commit      = (r_state == ST_RESP) && r_we;
`endif

  // With LATENCY=0 the RESP state is entered straight from the accept edge, so
  // the read must use the live inputs rather than the holding registers.
  assign w_acc_we     = w_accept ? we : r_we;
  assign w_acc_addr   = w_accept ? addr[ADDR_W+1:2] : r_addr;
  assign w_enter_resp = (w_next == ST_RESP) && (r_state != ST_RESP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdata <= 32'd0;
    end else if (w_enter_resp && !w_acc_we) begin
      r_rdata <= r_mem[w_acc_addr];
    end
  end

  // The write lands on the edge that closes the RESP cycle, so a read accepted
  // in the following IDLE cycle already sees the merged word.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (r_be[i]) begin
          r_mem[r_addr][8*i +: 8] <= r_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dm_4k_resp.sv
// tb/tb_dm_4k_resp.sv - scoreboard bench for dm_4k_resp at LATENCY=2 and LATENCY=0
`timescale 1ns/1ps
module tb_dm_4k_resp;

  typedef struct {
    bit          rd;
    logic [31:0] data;
    bit          err;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        req_s   [2];
  logic        we_s    [2];
  logic [11:0] addr_s  [2];
  logic [3:0]  be_s    [2];
  logic [31:0] wdata_s [2];
  logic [31:0] rdata_s [2];
  logic        ack_s   [2];
  logic        busy_s  [2];
`ifdef DM_ALIGN_CHK_EN
  logic        err_s   [2];
`endif

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   errors = 0;

  // index 0: LATENCY=0, index 1: LATENCY=2
  dm_4k_resp #(.ADDR_W(10), .LATENCY(0)) u_dut0 (
    .clk(clk), .reset(rst_n), .req(req_s[0]), .we(we_s[0]), .addr(addr_s[0]),
    .be(be_s[0]), .wdata(wdata_s[0]), .rdata(rdata_s[0]), .ack(ack_s[0]),
    .busy(busy_s[0])
`ifdef DM_ALIGN_CHK_EN
    , .err(err_s[0])
`endif
  );

  dm_4k_resp #(.ADDR_W(10), .LATENCY(2)) u_dut1 (
    .clk(clk), .reset(rst_n), .req(req_s[1]), .we(we_s[1]), .addr(addr_s[1]),
    .be(be_s[1]), .wdata(wdata_s[1]), .rdata(rdata_s[1]), .ack(ack_s[1]),
    .busy(busy_s[1])
`ifdef DM_ALIGN_CHK_EN
    , .err(err_s[1])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic sb_cmp(input int d, input exp_t e);
    chk($sformatf("busy_at_ack_dut%0d", d), 32'(busy_s[d]), 32'd1);
    if (e.rd) chk($sformatf("rdata_dut%0d", d), rdata_s[d], e.data);
`ifdef DM_ALIGN_CHK_EN
    chk($sformatf("err_dut%0d", d), 32'(err_s[d]), 32'(e.err));
`endif
  endtask

  task automatic sb_unexpected(input int d);
    checks++;
    errors++;
    $display("FAIL unexpected_ack_dut%0d: got ack=1 expected no pending access", d);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (ack_s[0]) begin
      if (q0.size() == 0) sb_unexpected(0);
      else begin e = q0.pop_front(); sb_cmp(0, e); end
    end
    if (ack_s[1]) begin
      if (q1.size() == 0) sb_unexpected(1);
      else begin e = q1.pop_front(); sb_cmp(1, e); end
    end
  end

  task automatic push(input int d, input bit rd, input logic [31:0] data, input bit err);
    exp_t e;
    e.rd = rd; e.data = data; e.err = err;
    if (d == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  // One complete access; hold=0 drops req right after the accept edge.
  task automatic access(input int d, input bit w, input logic [11:0] a, input logic [3:0] b,
                        input logic [31:0] wd, input logic [31:0] exp_rd,
                        input bit exp_err, input bit hold);
    int n, nb, lat;
    bit got;
    lat = (d == 0) ? 0 : 2;
    push(d, !w, exp_rd, exp_err);
    @(negedge clk); #1;
    req_s[d] = 1'b1; we_s[d] = w; addr_s[d] = a; be_s[d] = b; wdata_s[d] = wd;
    n = 0; nb = 0; got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      n++;
      if (busy_s[d]) nb++;
      if (!hold) req_s[d] = 1'b0;
      if (ack_s[d]) begin got = 1'b1; break; end
    end
    req_s[d] = 1'b0;
    chk($sformatf("ack_seen_dut%0d_%h", d, a), 32'(got), 32'd1);
    chk($sformatf("ack_latency_dut%0d_%h", d, a), 32'(n), 32'(lat + 1));
    chk($sformatf("busy_cycles_dut%0d_%h", d, a), 32'(nb), 32'(lat + 1));
  endtask

  task automatic chk_idle(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_ack_dut%0d", tag, d), 32'(ack_s[d]), 32'd0);
      chk($sformatf("%s_busy_dut%0d", tag, d), 32'(busy_s[d]), 32'd0);
      chk($sformatf("%s_rdata_dut%0d", tag, d), rdata_s[d], 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_s[d] = 1'b0; we_s[d] = 1'b0; addr_s[d] = 12'h0; be_s[d] = 4'h0; wdata_s[d] = 32'h0;
    end
    repeat (3) @(negedge clk);
    #1;
    chk_idle("reset");
    rst_n = 1'b1;

    // LATENCY=0: preload, then one request held high across three reads
    access(0, 1'b1, 12'h000, 4'hF, 32'hA0A0A0A0, 32'h0, 1'b0, 1'b1);
    access(0, 1'b1, 12'h004, 4'hF, 32'hB1B1B1B1, 32'h0, 1'b0, 1'b1);
    access(0, 1'b1, 12'h008, 4'hF, 32'hC2C2C2C2, 32'h0, 1'b0, 1'b1);
    push(0, 1'b1, 32'hA0A0A0A0, 1'b0);
    push(0, 1'b1, 32'hB1B1B1B1, 1'b0);
    push(0, 1'b1, 32'hC2C2C2C2, 1'b0);
    @(negedge clk); #1;
    req_s[0] = 1'b1; we_s[0] = 1'b0; addr_s[0] = 12'h000;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk); #1;
      chk($sformatf("b2b_ack_cycle%0d", k), 32'(ack_s[0]), 32'(k % 2));
      if (k == 1) addr_s[0] = 12'h004;
      if (k == 3) addr_s[0] = 12'h008;
    end
    req_s[0] = 1'b0;

    // LATENCY=2: word write/read
    access(1, 1'b1, 12'h020, 4'hF, 32'h12345678, 32'h0, 1'b0, 1'b1);
    access(1, 1'b0, 12'h020, 4'h0, 32'h0, 32'h12345678, 1'b0, 1'b1);
    // byte-enable merge
    access(1, 1'b1, 12'h040, 4'hF, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b1);
    access(1, 1'b1, 12'h040, 4'b0101, 32'h00AA00BB, 32'h0, 1'b0, 1'b1);
    access(1, 1'b0, 12'h040, 4'h0, 32'h0, 32'hFFAAFFBB, 1'b0, 1'b1);
    // top word, then an empty byte-enable write
    access(1, 1'b1, 12'hFFC, 4'hF, 32'hCAFEF00D, 32'h0, 1'b0, 1'b1);
    access(1, 1'b0, 12'hFFC, 4'h0, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1);
    access(1, 1'b1, 12'hFFC, 4'b0000, 32'h00000000, 32'h0, 1'b0, 1'b1);
    access(1, 1'b0, 12'hFFC, 4'h0, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1);
    // misaligned word write
`ifdef DM_ALIGN_CHK_EN
    access(1, 1'b1, 12'h043, 4'hF, 32'h11111111, 32'h0, 1'b1, 1'b1);
    access(1, 1'b0, 12'h040, 4'h0, 32'h0, 32'hFFAAFFBB, 1'b0, 1'b1);
`else
    access(1, 1'b1, 12'h043, 4'hF, 32'h11111111, 32'h0, 1'b0, 1'b1);
    access(1, 1'b0, 12'h040, 4'h0, 32'h0, 32'h11111111, 1'b0, 1'b1);
`endif
    // req dropped right after accept still completes
    access(1, 1'b0, 12'h020, 4'h0, 32'h0, 32'h12345678, 1'b0, 1'b0);

    // reset during WAIT of a write aborts it
    access(1, 1'b1, 12'h010, 4'hF, 32'h01010101, 32'h0, 1'b0, 1'b1);
    @(negedge clk); #1;
    req_s[1] = 1'b1; we_s[1] = 1'b1; addr_s[1] = 12'h010; be_s[1] = 4'hF; wdata_s[1] = 32'hDEADBEEF;
    @(negedge clk); #1;
    chk("busy_in_wait", 32'(busy_s[1]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_idle("abort");
    req_s[1] = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_idle("abort_hold");
    rst_n = 1'b1;
    access(1, 1'b0, 12'h010, 4'h0, 32'h0, 32'h01010101, 1'b0, 1'b1);

    repeat (4) @(negedge clk);
    chk("pending_dut0", 32'(q0.size()), 32'd0);
    chk("pending_dut1", 32'(q1.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
